// File: rtl/core_seq_ctrl.sv
// core_seq_ctrl: multi-cycle instruction sequencer for the RISC-V core.
// Owns the PC, fetches over a ready handshake, then steps each instruction
// through DECODE, EXEC and WB before fetching the next one. Stops in a sticky
// HALT on ECALL/EBREAK, halt request, fetch timeout or misaligned branch.
module core_seq_ctrl #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int          FETCH_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        instruction_RDY_BSY,
  input  logic [31:0] imem_data,
  output logic [31:0] instruction,
  output logic        dec_en,
  output logic        alu_en,
  output logic        RF_chip_enable,
  output logic        RF_write_enable,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        halt_req,
  output logic [31:0] pc,
  output logic [31:0] retired,
  output logic        halted,
  output logic [1:0]  err
);

  typedef enum logic [2:0] {
    StFetch,
    StDecode,
    StExec,
    StWb,
    StHalt
  } state_t;

  localparam int CNT_W = (FETCH_TIMEOUT > 1) ? $clog2(FETCH_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FETCH_TIMEOUT - 1);

  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [1:0] ERR_NONE      = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT   = 2'b01;
  localparam logic [1:0] ERR_MISALIGN  = 2'b10;

  state_t           r_state;
  logic [31:0]      r_pc;
  logic [31:0]      r_instruction;
  logic [31:0]      r_retired;
  logic [1:0]       r_err;
  logic [CNT_W-1:0] r_timeoutCnt;

  logic [6:0] w_opcode;
  logic [4:0] w_rd;
  logic       w_isSystem;
  logic       w_writesRd;
  logic       w_misaligned;

  // Fields of the latched instruction that WB needs to decide on writeback,
  // halting and whether a taken branch lands on a legal word boundary.
  always_comb begin
    w_opcode     = r_instruction[6:0];
    w_rd         = r_instruction[11:7];
    w_isSystem   = (w_opcode == OP_SYSTEM);
    w_writesRd   = (w_rd != 5'd0) && (w_opcode != OP_BRANCH) &&
                   (w_opcode != OP_STORE) && (w_opcode != OP_SYSTEM);
    w_misaligned = branch_taken && (branch_target[1:0] != 2'b00);
  end

  // Sequencer: walks FETCH -> DECODE -> EXEC -> WB and owns PC, counters and error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= StFetch;
      r_pc          <= RESET_PC;
      r_instruction <= 32'd0;
      r_retired     <= 32'd0;
      r_err         <= ERR_NONE;
      r_timeoutCnt  <= '0;
    end else begin
      case (r_state)
        StFetch: begin
          if (instruction_RDY_BSY) begin
            r_instruction <= imem_data;
            r_timeoutCnt  <= '0;
            r_state       <= StDecode;
          end else if (r_timeoutCnt == CNT_LAST) begin
            if (r_err == ERR_NONE) begin
              r_err <= ERR_TIMEOUT;
            end
            r_state <= StHalt;
          end else begin
            r_timeoutCnt <= r_timeoutCnt + CNT_W'(1);
          end
        end
        StDecode: begin
          r_state <= StExec;
        end
        StExec: begin
          r_state <= StWb;
        end
        StWb: begin
          r_retired <= r_retired + 32'd1;
          if (w_misaligned) begin
            if (r_err == ERR_NONE) begin
              r_err <= ERR_MISALIGN;
            end
            r_state <= StHalt;
          end else begin
            if (branch_taken) begin
              r_pc <= branch_target;
            end else begin
              r_pc <= r_pc + 32'd4;
            end
            if (w_isSystem || halt_req) begin
              r_state <= StHalt;
            end else begin
              r_state <= StFetch;
            end
          end
        end
        StHalt: begin
          r_state <= StHalt;
        end
        default: begin
          r_state <= StFetch;
        end
      endcase
    end
  end

  // Strobes follow the state register; all are forced low while reset is held.
  always_comb begin
    imem_req        = 1'b0;
    dec_en          = 1'b0;
    alu_en          = 1'b0;
    RF_chip_enable  = 1'b0;
    RF_write_enable = 1'b0;
    halted          = 1'b0;
    if (rst) begin
      case (r_state)
        StFetch: begin
          imem_req = 1'b1;
        end
        StDecode: begin
          dec_en         = 1'b1;
          RF_chip_enable = 1'b1;
        end
        StExec: begin
          alu_en = 1'b1;
        end
        StWb: begin
          RF_chip_enable  = w_writesRd;
          RF_write_enable = w_writesRd;
        end
        StHalt: begin
          halted = 1'b1;
        end
        default: begin
          imem_req = 1'b0;
        end
      endcase
    end
  end

  assign imem_addr   = r_pc;
  assign pc          = r_pc;
  assign instruction = r_instruction;
  assign retired     = r_retired;
  assign err         = r_err;

endmodule

// File: tb/tb_core_seq_ctrl.sv
// Bench for core_seq_ctrl: directed instructions with hand-computed results.
// Each issued instruction pushes its expected WB and post-WB picture into a
// queue; a monitor pops and compares when the DUT leaves EXEC.
module tb_core_seq_ctrl;

  logic        clk;
  logic        rst;
  logic        rdy;
  logic [31:0] imemData;
  logic        brTaken;
  logic [31:0] brTarget;
  logic        haltReq;

  logic        imemReq;
  logic [31:0] imemAddr;
  logic [31:0] instrOut;
  logic        decEn;
  logic        aluEn;
  logic        rfCe;
  logic        rfWe;
  logic [31:0] pcOut;
  logic [31:0] retiredOut;
  logic        haltedOut;
  logic [1:0]  errOut;

  logic        imemReq1;
  logic [31:0] imemAddr1;
  logic [31:0] instrOut1;
  logic        decEn1;
  logic        aluEn1;
  logic        rfCe1;
  logic        rfWe1;
  logic [31:0] pcOut1;
  logic [31:0] retiredOut1;
  logic        haltedOut1;
  logic [1:0]  errOut1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] instr;
    logic        ce;
    logic        we;
    logic [31:0] pc;
    logic [31:0] ret;
    logic        halted;
    logic [1:0]  err;
  } exp_t;

  exp_t sbQ[$];

  core_seq_ctrl #(
    .RESET_PC(32'h0000_0000),
    .FETCH_TIMEOUT(16)
  ) u_dut (
    .clk(clk),
    .rst(rst),
    .imem_req(imemReq),
    .imem_addr(imemAddr),
    .instruction_RDY_BSY(rdy),
    .imem_data(imemData),
    .instruction(instrOut),
    .dec_en(decEn),
    .alu_en(aluEn),
    .RF_chip_enable(rfCe),
    .RF_write_enable(rfWe),
    .branch_taken(brTaken),
    .branch_target(brTarget),
    .halt_req(haltReq),
    .pc(pcOut),
    .retired(retiredOut),
    .halted(haltedOut),
    .err(errOut)
  );

  // Second instance with a PC just below the wrap point, fed the same stimulus.
  core_seq_ctrl #(
    .RESET_PC(32'hFFFF_FFFC),
    .FETCH_TIMEOUT(16)
  ) u_dutWrap (
    .clk(clk),
    .rst(rst),
    .imem_req(imemReq1),
    .imem_addr(imemAddr1),
    .instruction_RDY_BSY(rdy),
    .imem_data(imemData),
    .instruction(instrOut1),
    .dec_en(decEn1),
    .alu_en(aluEn1),
    .RF_chip_enable(rfCe1),
    .RF_write_enable(rfWe1),
    .branch_taken(brTaken),
    .branch_target(brTarget),
    .halt_req(haltReq),
    .pc(pcOut1),
    .retired(retiredOut1),
    .halted(haltedOut1),
    .err(errOut1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Hold reset, check reset values, release on a falling edge (DUT in FETCH).
  task automatic doReset();
    repeat (2) @(posedge clk);
    #1;
    rdy      = 1'b0;
    haltReq  = 1'b0;
    brTaken  = 1'b0;
    brTarget = 32'd0;
    imemData = 32'd0;
    rst      = 1'b0;
    #1;
    checkOutput("rst_pc", pcOut, 32'h0);
    checkOutput("rst_instr", instrOut, 32'h0);
    checkOutput("rst_retired", retiredOut, 32'h0);
    checkOutput("rst_err", errOut, 2'b00);
    checkOutput("rst_halted", haltedOut, 1'b0);
    checkOutput("rst_strobes", {imemReq, decEn, aluEn, rfCe, rfWe}, 5'b0);
    checkOutput("rst_wrap_pc", pcOut1, 32'hFFFF_FFFC);
    checkOutput("rst_wrap_misc", {instrOut1, retiredOut1, imemReq1, decEn1, aluEn1,
                                  rfCe1, rfWe1, haltedOut1, errOut1}, 64'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("rel_imem_req", imemReq, 1'b1);
    checkOutput("rel_imem_addr", imemAddr, 32'h0);
    checkOutput("rel_wrap_addr", imemAddr1, 32'hFFFF_FFFC);
  endtask

  // Issue one instruction from FETCH and walk it through to the state after WB.
  task automatic applyStimulus(input logic [31:0] instrWord, input int waitCycles,
                               input logic br, input logic [31:0] tgt,
                               input logic haltInWb, input logic haltInExec,
                               input logic expCe, input logic expWe,
                               input logic [31:0] expPc, input logic [31:0] expRet,
                               input logic expHalted, input logic [1:0] expErr);
    exp_t e;
    for (int i = 0; i < waitCycles; i++) begin
      rdy = 1'b0;
      @(posedge clk);
      #1;
    end
    rdy      = 1'b1;
    imemData = instrWord;
    e.instr  = instrWord;
    e.ce     = expCe;
    e.we     = expWe;
    e.pc     = expPc;
    e.ret    = expRet;
    e.halted = expHalted;
    e.err    = expErr;
    sbQ.push_back(e);
    @(posedge clk);
    #1;
    rdy      = 1'b0;
    imemData = 32'hDEAD_BEEF;
    checkOutput("dec_instr", instrOut, instrWord);
    checkOutput("dec_strobes", {imemReq, decEn, aluEn, rfCe, rfWe}, 5'b01010);
    @(posedge clk);
    #1;
    checkOutput("exec_strobes", {imemReq, decEn, aluEn, rfCe, rfWe}, 5'b00100);
    haltReq = haltInExec;
    @(posedge clk);
    #1;
    haltReq  = haltInWb;
    brTaken  = br;
    brTarget = tgt;
    @(posedge clk);
    #1;
    haltReq  = 1'b0;
    brTaken  = 1'b0;
    brTarget = 32'd0;
  endtask

  // Monitor: on leaving EXEC, compare WB strobes, then the post-WB state.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst && aluEn && (sbQ.size() > 0)) begin
        e = sbQ.pop_front();
        @(negedge clk);
        checkOutput("wb_instr", instrOut, e.instr);
        checkOutput("wb_rf_ce", rfCe, e.ce);
        checkOutput("wb_rf_we", rfWe, e.we);
        checkOutput("wb_dec_alu", {decEn, aluEn, imemReq}, 3'b000);
        @(negedge clk);
        checkOutput("post_pc", pcOut, e.pc);
        checkOutput("post_retired", retiredOut, e.ret);
        checkOutput("post_halted", haltedOut, e.halted);
        checkOutput("post_err", errOut, e.err);
      end
    end
  end

  initial begin
    rst      = 1'b1;
    rdy      = 1'b0;
    imemData = 32'd0;
    brTaken  = 1'b0;
    brTarget = 32'd0;
    haltReq  = 1'b0;
    #2;
    rst = 1'b0;

    // addi x2,x1,3 fetched with immediate ready
    doReset();
    applyStimulus(32'h0030_8113, 0, 1'b0, 32'h0, 1'b0, 1'b0,
                  1'b1, 1'b1, 32'h4, 32'd1, 1'b0, 2'b00);
    checkOutput("wrap_pc", pcOut1, 32'h0);
    checkOutput("wrap_retired", retiredOut1, 32'd1);
    // beq taken to an aligned target: no RF access in WB
    applyStimulus(32'h0000_0463, 0, 1'b1, 32'h100, 1'b0, 1'b0,
                  1'b0, 1'b0, 32'h100, 32'd2, 1'b0, 2'b00);
    // store after a short fetch stall
    applyStimulus(32'h0020_A023, 3, 1'b0, 32'h0, 1'b0, 1'b0,
                  1'b0, 1'b0, 32'h104, 32'd3, 1'b0, 2'b00);
    // halt_req only during EXEC is ignored
    applyStimulus(32'h0030_8113, 0, 1'b0, 32'h0, 1'b0, 1'b1,
                  1'b1, 1'b1, 32'h108, 32'd4, 1'b0, 2'b00);
    // add x0,x0,x0: rd=0 so no write
    applyStimulus(32'h0000_0033, 1, 1'b0, 32'h0, 1'b0, 1'b0,
                  1'b0, 1'b0, 32'h10C, 32'd5, 1'b0, 2'b00);
    // halt_req in WB: writes, advances PC, then halts
    applyStimulus(32'h0030_8113, 0, 1'b0, 32'h0, 1'b1, 1'b0,
                  1'b1, 1'b1, 32'h110, 32'd6, 1'b1, 2'b00);
    rdy = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rdy = 1'b0;
    checkOutput("halt_hold", {haltedOut, imemReq, decEn, aluEn}, 4'b1000);
    checkOutput("halt_hold_pc", pcOut, 32'h110);
    checkOutput("halt_hold_ret", retiredOut, 32'd6);

    // ECALL halts with PC advanced
    doReset();
    applyStimulus(32'h0000_0073, 0, 1'b0, 32'h0, 1'b0, 1'b0,
                  1'b0, 1'b0, 32'h4, 32'd1, 1'b1, 2'b00);

    // beq to a misaligned target: err=10, PC held
    doReset();
    applyStimulus(32'h0000_0463, 0, 1'b1, 32'h102, 1'b0, 1'b0,
                  1'b0, 1'b0, 32'h0, 32'd1, 1'b1, 2'b10);

    // Fetch timeout after 16 cycles without ready
    doReset();
    rdy = 1'b0;
    repeat (15) @(posedge clk);
    #1;
    checkOutput("to_before", {haltedOut, imemReq}, 2'b01);
    checkOutput("to_before_err", errOut, 2'b00);
    @(posedge clk);
    #1;
    checkOutput("to_halted", {haltedOut, imemReq}, 2'b10);
    checkOutput("to_err", errOut, 2'b01);
    checkOutput("to_pc", pcOut, 32'h0);

    // Ready on exactly the 16th cycle wins over timeout
    doReset();
    applyStimulus(32'h0030_8113, 15, 1'b0, 32'h0, 1'b0, 1'b0,
                  1'b1, 1'b1, 32'h4, 32'd1, 1'b0, 2'b00);

    // Reset asserted during EXEC takes effect immediately
    doReset();
    rdy      = 1'b1;
    imemData = 32'h0030_8113;
    @(posedge clk);
    #1;
    rdy = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("mid_exec", aluEn, 1'b1);
    rst = 1'b0;
    #1;
    checkOutput("mid_rst_strobes", {imemReq, decEn, aluEn, rfCe, rfWe}, 5'b0);
    checkOutput("mid_rst_instr", instrOut, 32'h0);
    checkOutput("mid_rst_state", {haltedOut, errOut, retiredOut, pcOut}, 67'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("mid_after_fetch", {imemReq, decEn, aluEn}, 3'b100);
    checkOutput("mid_after_addr", imemAddr, 32'h0);

    repeat (3) @(posedge clk);
    checkOutput("sb_drained", sbQ.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
